// File: rtl/opacc_seq_ctrl_if.sv
// Command, operand, datapath and read-out bundle for the opacc sequencer.
interface opacc_seq_ctrl_if #(
  parameter int DW   = 512,
  parameter int ROWS = 16
);
  localparam int RW = $clog2(ROWS);

  logic          cmd_valid;
  logic          cmd_ready;
  logic [RW-1:0] cmd_rows_m1;
  logic [1:0]    cmd_eew;
  logic          cmd_signed;
  logic          cmd_clear;
  logic          cmd_drain;

  logic          opnd_valid;
  logic          opnd_ready;
  logic [DW-1:0] opnd_data;

  logic [DW-1:0] sized_src1_0a;
  logic [DW-1:0] sized_src2_0a;
  logic          mulen_0a;
  logic          issgn_a;
  logic          issgn_b;
  logic [1:0]    eew_0a;
  logic          acc_clr_0a;
  logic [RW-1:0] row_idx_0a;

  logic          rd_valid;
  logic          rd_ready;
  logic [RW-1:0] rd_row;

  logic          done;
  logic          err;

  modport master (
    output cmd_valid, cmd_rows_m1, cmd_eew, cmd_signed,
    output cmd_clear, cmd_drain, opnd_valid, opnd_data,
    output rd_ready,
    input  cmd_ready, opnd_ready, sized_src1_0a, sized_src2_0a,
    input  mulen_0a, issgn_a, issgn_b, eew_0a, acc_clr_0a,
    input  row_idx_0a, rd_valid, rd_row, done, err
  );

  modport slave (
    input  cmd_valid, cmd_rows_m1, cmd_eew, cmd_signed,
    input  cmd_clear, cmd_drain, opnd_valid, opnd_data,
    input  rd_ready,
    output cmd_ready, opnd_ready, sized_src1_0a, sized_src2_0a,
    output mulen_0a, issgn_a, issgn_b, eew_0a, acc_clr_0a,
    output row_idx_0a, rd_valid, rd_row, done, err
  );
endinterface

// File: rtl/opacc_seq_ctrl.sv
// Outer-product accumulator sequencer: B beat, N A-row beats, flush, drain.
// OPACC_SEQ_PERF_EN adds saturating mulen/stall performance counters.
module opacc_seq_ctrl #(
  parameter int DW   = 512,
  parameter int ROWS = 16,
  parameter int PIPE = 3
) (
  input  logic clk,
  input  logic reset_n,
  opacc_seq_ctrl_if.slave bus
`ifdef OPACC_SEQ_PERF_EN
  ,
  output logic [31:0] perf_mac_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);
  localparam int RW = $clog2(ROWS);
  localparam int FW = $clog2(PIPE + 1);

  typedef enum logic [2:0] {
    IDLE, LDB, MAC, FLUSH, DRAIN
  } state_e;

  state_e        state_q;
  logic          cmd_ready_q;
  logic          opnd_ready_q;
  logic [DW-1:0] src1_q;
  logic [DW-1:0] src2_q;
  logic          mulen_q;
  logic          issgn_q;
  logic [1:0]    eew_q;
  logic          acc_clr_q;
  logic [RW-1:0] row_idx_q;
  logic          rd_valid_q;
  logic [RW-1:0] rd_row_q;
  logic          done_q;
  logic          err_q;
  logic [RW-1:0] cnt_q;
  logic [FW-1:0] flush_q;
  logic [RW-1:0] rows_q;
  logic          clear_q;
  logic          drain_q;

  logic cmd_hs_d;
  logic beat_d;
  logic rd_hs_d;

  assign cmd_hs_d = bus.cmd_valid & cmd_ready_q;
  assign beat_d   = bus.opnd_valid & opnd_ready_q;
  assign rd_hs_d  = rd_valid_q & bus.rd_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cmd_ready_q  <= 1'b1;
      opnd_ready_q <= 1'b0;
      src1_q       <= '0;
      src2_q       <= '0;
      mulen_q      <= 1'b0;
      issgn_q      <= 1'b0;
      eew_q        <= '0;
      acc_clr_q    <= 1'b0;
      row_idx_q    <= '0;
      rd_valid_q   <= 1'b0;
      rd_row_q     <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
      flush_q      <= '0;
      rows_q       <= '0;
      clear_q      <= 1'b0;
      drain_q      <= 1'b0;
    end else begin
      mulen_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (cmd_hs_d) begin
            if (bus.cmd_eew == 2'd3) begin
              err_q <= 1'b1;
            end else begin
              rows_q       <= bus.cmd_rows_m1;
              clear_q      <= bus.cmd_clear;
              drain_q      <= bus.cmd_drain;
              issgn_q      <= bus.cmd_signed;
              eew_q        <= bus.cmd_eew;
              cmd_ready_q  <= 1'b0;
              opnd_ready_q <= 1'b1;
              state_q      <= LDB;
            end
          end
        end
        LDB: begin
          if (beat_d) begin
            src2_q  <= bus.opnd_data;
            cnt_q   <= '0;
            state_q <= MAC;
          end
        end
        MAC: begin
          if (beat_d) begin
            src1_q    <= bus.opnd_data;
            mulen_q   <= 1'b1;
            row_idx_q <= cnt_q;
            acc_clr_q <= clear_q;
            cnt_q     <= cnt_q + RW'(1);
            if (cnt_q == rows_q) begin
              opnd_ready_q <= 1'b0;
              flush_q      <= FW'(PIPE);
              state_q      <= FLUSH;
            end
          end
        end
        FLUSH: begin
          // last mulen needs PIPE cycles to land in the accumulator
          if (flush_q == '0) begin
            if (drain_q) begin
              rd_valid_q <= 1'b1;
              rd_row_q   <= '0;
              state_q    <= DRAIN;
            end else begin
              done_q      <= 1'b1;
              cmd_ready_q <= 1'b1;
              state_q     <= IDLE;
            end
          end else begin
            flush_q <= flush_q - FW'(1);
          end
        end
        DRAIN: begin
          if (rd_hs_d) begin
            if (rd_row_q == rows_q) begin
              rd_valid_q  <= 1'b0;
              done_q      <= 1'b1;
              cmd_ready_q <= 1'b1;
              state_q     <= IDLE;
            end else begin
              rd_row_q <= rd_row_q + RW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef OPACC_SEQ_PERF_EN
  logic [31:0] mac_cnt_q;
  logic [31:0] stall_cnt_q;
  logic        stall_d;

  assign stall_d = ((state_q == LDB) | (state_q == MAC)) & ~bus.opnd_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mac_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (mulen_q && (mac_cnt_q != '1))
        mac_cnt_q <= mac_cnt_q + 32'd1;
      if (stall_d && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign perf_mac_cnt   = mac_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`endif

  assign bus.cmd_ready     = cmd_ready_q;
  assign bus.opnd_ready    = opnd_ready_q;
  assign bus.sized_src1_0a = src1_q;
  assign bus.sized_src2_0a = src2_q;
  assign bus.mulen_0a      = mulen_q;
  assign bus.issgn_a       = issgn_q;
  assign bus.issgn_b       = issgn_q;
  assign bus.eew_0a        = eew_q;
  assign bus.acc_clr_0a    = acc_clr_q;
  assign bus.row_idx_0a    = row_idx_q;
  assign bus.rd_valid      = rd_valid_q;
  assign bus.rd_row        = rd_row_q;
  assign bus.done          = done_q;
  assign bus.err           = err_q;
endmodule

// File: tb/tb_opacc_seq_ctrl.sv
// Self-checking bench for opacc_seq_ctrl: vector table, corner sequences, random commands.
module tb_opacc_seq_ctrl;
  localparam int DW   = 64;
  localparam int ROWS = 16;
  localparam int PIPE = 3;
  localparam int RW   = $clog2(ROWS);

  typedef struct {
    int rows_m1;
    int eew;
    bit sgn;
    bit clr;
    bit drain;
    int exp_mulen;
    bit exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  opacc_seq_ctrl_if #(.DW(DW), .ROWS(ROWS)) bus();

`ifdef OPACC_SEQ_PERF_EN
  logic [31:0] perf_mac_cnt;
  logic [31:0] perf_stall_cnt;
  logic [31:0] p0;
`endif

  opacc_seq_ctrl #(.DW(DW), .ROWS(ROWS), .PIPE(PIPE)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
`ifdef OPACC_SEQ_PERF_EN
    ,
    .perf_mac_cnt(perf_mac_cnt),
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ordy = 0;

  int            m_cyc[$];
  int            m_row[$];
  logic [DW-1:0] m_s1[$];
  logic [DW-1:0] m_s2[$];
  bit            m_clr[$];
  bit            m_sa[$];
  bit            m_sb[$];
  int            m_eew[$];
  int            done_cyc[$];
  int            err_cyc[$];
  int            rd_cyc[$];
  int            rd_rows[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.mulen_0a) begin
        m_cyc.push_back(cyc);
        m_row.push_back(int'(bus.row_idx_0a));
        m_s1.push_back(bus.sized_src1_0a);
        m_s2.push_back(bus.sized_src2_0a);
        m_clr.push_back(bus.acc_clr_0a);
        m_sa.push_back(bus.issgn_a);
        m_sb.push_back(bus.issgn_b);
        m_eew.push_back(int'(bus.eew_0a));
      end
      if (bus.done) done_cyc.push_back(cyc);
      if (bus.err) err_cyc.push_back(cyc);
      if (bus.rd_valid && bus.rd_ready) begin
        rd_rows.push_back(int'(bus.rd_row));
        rd_cyc.push_back(cyc);
      end
      if (bus.opnd_ready) ordy++;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic rst_chk(input string tag);
    chk({tag, "_ctl"},
        {45'd0, bus.cmd_ready, bus.opnd_ready, bus.mulen_0a,
         bus.acc_clr_0a, bus.rd_valid, bus.done, bus.err,
         bus.issgn_a, bus.issgn_b, bus.eew_0a, bus.row_idx_0a,
         bus.rd_row},
        {45'd0, 1'b1, 18'd0});
    chk({tag, "_src1"}, bus.sized_src1_0a, 64'd0);
    chk({tag, "_src2"}, bus.sized_src2_0a, 64'd0);
  endtask

  task automatic clear_mon();
    m_cyc.delete(); m_row.delete(); m_s1.delete(); m_s2.delete();
    m_clr.delete(); m_sa.delete(); m_sb.delete(); m_eew.delete();
    done_cyc.delete(); err_cyc.delete();
    rd_cyc.delete(); rd_rows.delete();
  endtask

  task automatic run_cmd(input vec_t v, input bit rnd_v, input bit use_pat,
                         input logic [31:0] pat, input bit rnd_rd,
                         input bit stall_r1, input int abort_row,
                         output bit aborted);
    logic [DW-1:0] beats[$];
    int  n, idx, hold, acc_cyc, opr0, last;
    bit  hs, fin, held;
    n = v.rows_m1 + 2;
    for (int i = 0; i < n; i++) beats.push_back({$urandom, $urandom});
    clear_mon();
    opr0 = ordy;
    aborted = 1'b0;
    bus.cmd_valid   = 1'b1;
    bus.cmd_rows_m1 = RW'(v.rows_m1);
    bus.cmd_eew     = 2'(v.eew);
    bus.cmd_signed  = v.sgn;
    bus.cmd_clear   = v.clr;
    bus.cmd_drain   = v.drain;
    hs = 1'b0;
    for (int t = 0; t < 50 && !hs; t++) begin
      @(negedge clk);
      hs = bus.cmd_ready;
      @(posedge clk); #1;
    end
    bus.cmd_valid = 1'b0;
    acc_cyc = cyc;
    chk("cmd_accept", hs, 1);
    idx = 0; fin = 1'b0; hold = 0;
    for (int k = 0; k < 600 && !fin; k++) begin
      if (idx < n) begin
        bus.opnd_valid = use_pat ? ((k < 32) ? pat[k] : 1'b1) :
                         rnd_v ? ($urandom_range(3) != 0) : 1'b1;
        bus.opnd_data = beats[idx];
      end else begin
        bus.opnd_valid = 1'b0;
      end
      held = 1'b0;
      if (stall_r1 && bus.rd_valid && bus.rd_row == RW'(1) && hold < 3) begin
        bus.rd_ready = 1'b0;
        hold++;
        held = 1'b1;
      end else begin
        bus.rd_ready = rnd_rd ? ($urandom_range(1) == 1) : 1'b1;
      end
      @(negedge clk);
      if (held) begin
        chk("rd_hold_valid", bus.rd_valid, 1);
        chk("rd_hold_row", bus.rd_row, 1);
      end
      if (bus.opnd_valid && bus.opnd_ready) idx++;
      if (abort_row >= 0 && bus.mulen_0a &&
          int'(bus.row_idx_0a) == abort_row) begin
        aborted = 1'b1;
        fin = 1'b1;
      end
      if (bus.done || bus.err) fin = 1'b1;
      if (!fin) begin
        @(posedge clk); #1;
      end
    end
    if (aborted) return;
    bus.opnd_valid = 1'b0;
    bus.rd_ready   = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("cmd_timeout", fin, 1);
    chk("cmd_ready_end", bus.cmd_ready, 1);
    chk("mulen_cnt", m_cyc.size(), v.exp_mulen);
    if (v.exp_err) begin
      chk("err_cnt", err_cyc.size(), 1);
      if (err_cyc.size() > 0) chk("err_lat", err_cyc[0] - acc_cyc, 0);
      chk("err_no_opnd_ready", ordy - opr0, 0);
      chk("err_no_done", done_cyc.size(), 0);
    end else begin
      chk("no_err", err_cyc.size(), 0);
      chk("done_cnt", done_cyc.size(), 1);
      for (int i = 0; i < m_cyc.size() && i < n - 1; i++) begin
        chk("row_idx", m_row[i], i);
        chk("src1", m_s1[i], beats[i+1]);
        chk("src2", m_s2[i], beats[0]);
        chk("acc_clr", m_clr[i], v.clr);
        chk("issgn_ab", {m_sa[i], m_sb[i]}, {v.sgn, v.sgn});
        chk("eew", m_eew[i], v.eew);
        if (i > 0 && !rnd_v && !use_pat)
          chk("mulen_b2b", m_cyc[i] - m_cyc[i-1], 1);
      end
      if (m_cyc.size() > 0) begin
        last = m_cyc[m_cyc.size()-1];
        if (!rnd_v && !use_pat)
          chk("first_lat", m_cyc[0] - acc_cyc, 2);
        else
          chk("first_lat_min", (m_cyc[0] - acc_cyc) >= 2, 1);
        if (!v.drain && done_cyc.size() > 0)
          chk("done_lat", done_cyc[0] - last, PIPE + 1);
      end
      if (v.drain) begin
        chk("rd_cnt", rd_rows.size(), v.rows_m1 + 1);
        for (int i = 0; i < rd_rows.size(); i++) chk("rd_row", rd_rows[i], i);
        if (rd_cyc.size() > 0 && done_cyc.size() > 0)
          chk("drain_done_lat", done_cyc[0] - rd_cyc[rd_cyc.size()-1], 1);
      end else begin
        chk("no_rd", rd_rows.size(), 0);
      end
    end
  endtask

  vec_t vecs[6];
  vec_t v;
  bit   ab;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cmd_valid = 0; bus.cmd_rows_m1 = '0; bus.cmd_eew = '0;
    bus.cmd_signed = 0; bus.cmd_clear = 0; bus.cmd_drain = 0;
    bus.opnd_valid = 0; bus.opnd_data = '0; bus.rd_ready = 0;
    vecs[0] = '{3, 0, 1, 1, 0, 4, 0};
    vecs[1] = '{15, 2, 0, 0, 0, 16, 0};
    vecs[2] = '{0, 1, 1, 0, 0, 1, 0};
    vecs[3] = '{0, 0, 0, 1, 1, 1, 0};
    vecs[4] = '{3, 3, 1, 1, 1, 0, 1};
    vecs[5] = '{7, 1, 0, 1, 1, 8, 0};

    repeat (3) @(posedge clk);
    #1;
    rst_chk("reset");
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
`ifdef OPACC_SEQ_PERF_EN
      p0 = perf_mac_cnt;
`endif
      run_cmd(vecs[i], 0, 0, 32'd0, 0, 0, -1, ab);
`ifdef OPACC_SEQ_PERF_EN
      chk("perf_mac", perf_mac_cnt - p0, vecs[i].exp_mulen);
`endif
    end

    v = '{1, 0, 0, 0, 0, 2, 0};
    run_cmd(v, 0, 1, 32'b10011, 0, 0, -1, ab);
    if (m_cyc.size() >= 2) chk("bubble_gap", m_cyc[1] - m_cyc[0], 3);

    v = '{2, 1, 1, 0, 1, 3, 0};
    run_cmd(v, 0, 0, 32'd0, 0, 1, -1, ab);

    v = '{5, 0, 1, 1, 0, 6, 0};
    run_cmd(v, 0, 0, 32'd0, 0, 0, 2, ab);
    chk("abort_reached", ab, 1);
    #1;
    reset_n = 1'b0;
    #1;
    rst_chk("midreset");
    bus.opnd_valid = 1'b0;
    bus.rd_ready = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    v = '{2, 0, 0, 1, 0, 3, 0};
    run_cmd(v, 0, 0, 32'd0, 0, 0, -1, ab);

    for (int r = 0; r < 25; r++) begin
      v.rows_m1   = $urandom_range(ROWS - 1);
      v.eew       = $urandom_range(3);
      v.sgn       = $urandom_range(1) == 1;
      v.clr       = $urandom_range(1) == 1;
      v.drain     = $urandom_range(1) == 1;
      v.exp_err   = (v.eew == 3);
      v.exp_mulen = v.exp_err ? 0 : v.rows_m1 + 1;
      run_cmd(v, 1, 0, 32'd0, 1, 0, -1, ab);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
